// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake bus between inverse ShiftRows, the iterative InvSubBytes block and AddRoundKey.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE state bytes per cycle in place,
// holding the finished state until the downstream handshake.
module inv_sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_sub_bytes_iter_if.slave  bus
);
    localparam int unsigned STEPS  = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned LANE_W = 8 * BYTES_PER_CYCLE;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   step_q;
    logic [127:0]       work_q;
    logic               out_valid_q;
    logic [6:0]         lane_base;
    logic [LANE_W-1:0]  lane_in;
    logic [LANE_W-1:0]  lane_out;

    // Bit offset of the byte lane handled at the current step.
    always_comb begin
        lane_base = 7'(32'(step_q) * LANE_W);
        lane_in   = work_q[lane_base +: LANE_W];
    end

    // One shared inverse S-box lookup per byte lane.
    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lut
        assign lane_out[8*b +: 8] = INV_SBOX[lane_in[8*b +: 8]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_data;
                        step_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q[lane_base +: LANE_W] <= lane_out;
                    if (step_q == CNT_W'(STEPS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    // Output handshake may coincide with the next capture.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            work_q  <= bus.in_data;
                            step_q  <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed and random checks of inv_sub_bytes_iter at BYTES_PER_CYCLE = 4, 1 and 16.
module tb_inv_sub_bytes_iter;
    localparam logic [127:0] BYTES_IN  = 128'h00000000_00000000_00000000_16ED7C63;
    localparam logic [127:0] BYTES_EXP = 128'h52525252_52525252_52525252_FF530100;
    localparam logic [127:0] ZERO_EXP  = {16{8'h52}};

    logic         clk;
    logic         rst;
    logic [2:0]   iv;
    logic [2:0]   ordy;
    logic [127:0] id [3];
    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [127:0] od [3];
    int           checks;
    int           errors;
    int           exp_lat [3];
    logic [7:0]   ref_tab [256];

    inv_sub_bytes_iter_if bus0 ();
    inv_sub_bytes_iter_if bus1 ();
    inv_sub_bytes_iter_if bus2 ();

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.in_valid = iv[0];
    assign bus1.in_valid = iv[1];
    assign bus2.in_valid = iv[2];
    assign bus0.in_data  = id[0];
    assign bus1.in_data  = id[1];
    assign bus2.in_data  = id[2];
    assign bus0.out_ready = ordy[0];
    assign bus1.out_ready = ordy[1];
    assign bus2.out_ready = ordy[2];
    assign ov[0] = bus0.out_valid;
    assign ov[1] = bus1.out_valid;
    assign ov[2] = bus2.out_valid;
    assign ir[0] = bus0.in_ready;
    assign ir[1] = bus1.in_ready;
    assign ir[2] = bus2.in_ready;
    assign od[0] = bus0.out_data;
    assign od[1] = bus1.out_data;
    assign od[2] = bus2.out_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse affine transform followed by the GF(2^8) inverse (x^254).
    function automatic logic [7:0] ref_inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        p = b;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Starts at a falling edge; returns the result and cycles from accept to out_valid.
    task automatic run_block(input int idx, input logic [127:0] d,
                             output logic [127:0] res, output int lat);
        int n;
        iv[idx]   = 1'b1;
        id[idx]   = d;
        ordy[idx] = 1'b0;
        @(negedge clk);
        iv[idx] = 1'b0;
        id[idx] = '0;
        n = 0;
        while (!ov[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = ov[idx] ? n : -1;
        res = od[idx];
    endtask

    task automatic pop(input int idx);
        ordy[idx] = 1'b1;
        @(negedge clk);
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || od[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, expected 1 0 0", i, ir[i], ov[i], od[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_state();
        logic [127:0] res;
        int lat;
        run_block(0, 128'h0, res, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL zero_latency: got %0d, expected 4", lat);
        end
        checks++;
        if (res !== ZERO_EXP) begin
            errors++;
            $display("FAIL zero_data: got %h, expected %h", res, ZERO_EXP);
        end
        pop(0);
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_release: out_valid=%b in_ready=%b, expected 0 1", ov[0], ir[0]);
        end
    endtask

    task automatic test_byte_positions();
        logic [127:0] res;
        int lat;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b, expected 1", ir[0]);
        end
        run_block(0, BYTES_IN, res, lat);
        checks++;
        if (res !== BYTES_EXP || lat !== 4) begin
            errors++;
            $display("FAIL byte_positions: got %h lat %0d, expected %h lat 4", res, lat, BYTES_EXP);
        end
        pop(0);
    endtask

    task automatic test_output_stall();
        logic [127:0] res;
        int lat;
        run_block(0, BYTES_IN, res, lat);
        checks++;
        if (res !== BYTES_EXP) begin
            errors++;
            $display("FAIL stall_result: got %h, expected %h", res, BYTES_EXP);
        end
        for (int c = 0; c < 10; c++) begin
            iv[0]   = 1'b1;
            id[0]   = {4{32'hA5A5_0F0F}};
            ordy[0] = 1'b0;
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== BYTES_EXP || ir[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle %0d: out_valid=%b in_ready=%b out_data=%h, expected 1 0 %h",
                         c, ov[0], ir[0], od[0], BYTES_EXP);
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_in_ready_follows_out_ready: got %b, expected 1", ir[0]);
        end
        @(negedge clk);
        ordy[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b, expected 0", ov[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d [4];
        logic [127:0] e [4];
        int r;
        int cyc;
        int last;
        d[0] = 128'h0;          e[0] = ZERO_EXP;
        d[1] = BYTES_IN;        e[1] = BYTES_EXP;
        d[2] = {16{8'h63}};     e[2] = 128'h0;
        d[3] = {16{8'h7C}};     e[3] = {16{8'h01}};
        iv[0]   = 1'b1;
        id[0]   = d[0];
        ordy[0] = 1'b1;
        @(negedge clk);
        r = 0;
        cyc = 0;
        last = 0;
        while (r < 4 && cyc < 60) begin
            if (ov[0]) begin
                checks++;
                if (od[0] !== e[r] || ir[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h in_ready=%b, expected %h in_ready=1", r, od[0], ir[0], e[r]);
                end
                checks++;
                if ((r == 0 && cyc !== 4) || (r > 0 && (cyc - last) !== 5)) begin
                    errors++;
                    $display("FAIL b2b_timing[%0d]: result at cycle %0d (previous %0d), expected latency 4 then period 5",
                             r, cyc, last);
                end
                last = cyc;
                r++;
                if (r < 4) id[0] = d[r];
                else iv[0] = 1'b0;
            end else begin
                id[0] = {4{32'hDEAD_BEEF}};
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (r !== 4 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results out_valid=%b, expected 4 results out_valid=0", r, ov[0]);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] res;
        int lat;
        bit seen;
        iv[0]   = 1'b1;
        id[0]   = BYTES_IN;
        ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || od[0] !== 128'h0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b out_data=%h in_ready=%b, expected 0 0 1", ov[0], od[0], ir[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        ordy[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        ordy[0] = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: out_valid seen=%b, expected 0", seen);
        end
        run_block(0, BYTES_IN, res, lat);
        checks++;
        if (res !== BYTES_EXP || lat !== 4) begin
            errors++;
            $display("FAIL post_reset_block: got %h lat %0d, expected %h lat 4", res, lat, BYTES_EXP);
        end
        pop(0);
    endtask

    task automatic test_param_variants();
        logic [127:0] res;
        int lat;
        for (int idx = 1; idx < 3; idx++) begin
            run_block(idx, 128'h0, res, lat);
            checks++;
            if (res !== ZERO_EXP || lat !== exp_lat[idx]) begin
                errors++;
                $display("FAIL param_zero[%0d]: got %h lat %0d, expected %h lat %0d",
                         idx, res, lat, ZERO_EXP, exp_lat[idx]);
            end
            pop(idx);
            run_block(idx, BYTES_IN, res, lat);
            checks++;
            if (res !== BYTES_EXP || lat !== exp_lat[idx]) begin
                errors++;
                $display("FAIL param_bytes[%0d]: got %h lat %0d, expected %h lat %0d",
                         idx, res, lat, BYTES_EXP, exp_lat[idx]);
            end
            pop(idx);
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] res;
        int lat;
        int nblk;
        for (int idx = 0; idx < 3; idx++) begin
            nblk = (idx == 0) ? 1000 : 100;
            for (int k = 0; k < nblk; k++) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                for (int b = 0; b < 16; b++) e[8*b +: 8] = ref_tab[d[8*b +: 8]];
                run_block(idx, d, res, lat);
                checks++;
                if (res !== e || lat !== exp_lat[idx]) begin
                    errors++;
                    $display("FAIL random[%0d] block %0d: in %h got %h lat %0d, expected %h lat %0d",
                             idx, k, d, res, lat, e, exp_lat[idx]);
                end
                pop(idx);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_lat[0] = 4;
        exp_lat[1] = 16;
        exp_lat[2] = 1;
        for (int i = 0; i < 256; i++) ref_tab[i] = ref_inv_sbox(8'(i));
        iv   = '0;
        ordy = '0;
        for (int i = 0; i < 3; i++) id[i] = '0;

        test_reset();
        test_zero_state();
        test_byte_positions();
        test_output_stall();
        test_back_to_back();
        test_reset_mid_busy();
        test_param_variants();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
